// File: rtl/fft_pkg.sv
// Shared constants, complex-word type and index helpers for the FFT datapath,
// its output-side capture block and the bench.
package fft_pkg;

   localparam int unsigned N         = 128;
   localparam int unsigned LANES     = 4;
   localparam int unsigned NBITS_out = 21;

   typedef struct packed {
      logic signed [NBITS_out-1:0] re;
      logic signed [NBITS_out-1:0] im;
   } cplx_t;

   // Reverses the low log2n bits of i; bits above log2n are dropped.
   function automatic int unsigned bitrev_idx(input int unsigned i, input int unsigned log2n);
      int unsigned r;
      r = 0;
      for (int unsigned b = 0; b < 32; b++) begin
         if (b < log2n) r = (r << 1) | ((i >> b) & 32'd1);
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_lane_ram.sv
// One lane buffer: simple dual-port RAM, synchronous write, registered read
// that holds its output while re is low.
module fft_lane_ram
   import fft_pkg::*;
#(
   parameter int unsigned DEPTH = N / LANES,
   parameter int unsigned WIDTH = 2 * NBITS_out,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fft_frame_unloader.sv
// Snapshots one N-point frame from the 4-lane FFT output bus into lane buffers,
// then drains it one sample per beat over a valid/ready stream.
module fft_frame_unloader
   import fft_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2*NBITS_out-1:0] fftOut0_up,
   input  logic [2*NBITS_out-1:0] fftOut0_down,
   input  logic [2*NBITS_out-1:0] fftOut1_up,
   input  logic [2*NBITS_out-1:0] fftOut1_down,
   input  logic                   frame_start,
   input  logic                   arm,
   input  logic                   bitrev,
   output logic [2*NBITS_out-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   busy
);

   localparam int unsigned W     = 2 * NBITS_out;
   localparam int unsigned NROWS = N / LANES;
   localparam int unsigned L2N   = $clog2(N);
   localparam int unsigned RW    = $clog2(NROWS);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN} state_t;

   state_t         state, state_nx;
   logic [RW-1:0]  row;
   logic           bitrev_q;
   logic [L2N:0]   rd_idx;
   logic [L2N-1:0] rd_k;
   logic           p1_valid, p1_last;
   logic [1:0]     p1_bank;
   logic           wr_en, rd_en, advance;
   logic [RW-1:0]  wr_row;
   logic [W-1:0]   lane_wdata [LANES];
   logic [W-1:0]   lane_rdata [LANES];

   always_comb begin
      lane_wdata[0] = fftOut0_up;
      lane_wdata[1] = fftOut0_down;
      lane_wdata[2] = fftOut1_up;
      lane_wdata[3] = fftOut1_down;
   end

   always_comb begin
      wr_en   = (state == S_ARMED && frame_start) || state == S_CAPTURE;
      wr_row  = (state == S_CAPTURE) ? row : '0;
      // Read stage and output register advance together; a stall freezes both.
      advance = !out_valid || out_ready;
      rd_en   = state == S_DRAIN && advance && rd_idx < (L2N+1)'(N);
      rd_k    = bitrev_q ? L2N'(bitrev_idx(32'(rd_idx[L2N-1:0]), L2N)) : rd_idx[L2N-1:0];
   end

   always_comb begin
      state_nx = state;
      busy     = state != S_IDLE;
      case (state)
         S_IDLE:    if (arm) state_nx = S_ARMED;
         S_ARMED:   if (frame_start) state_nx = S_CAPTURE;
         S_CAPTURE: if (row == RW'(NROWS-1)) state_nx = S_DRAIN;
         S_DRAIN:   if (out_valid && out_ready && out_last) state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fft_lane_ram #(.DEPTH(NROWS), .WIDTH(W)) u_ram (
         .clk   (clk),
         .we    (wr_en),
         .waddr (wr_row),
         .wdata (lane_wdata[g]),
         .re    (rd_en),
         .raddr (rd_k[L2N-1:2]),
         .rdata (lane_rdata[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         row       <= '0;
         bitrev_q  <= 1'b0;
         rd_idx    <= '0;
         p1_valid  <= 1'b0;
         p1_last   <= 1'b0;
         p1_bank   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && arm) bitrev_q <= bitrev;
         if (state == S_ARMED && frame_start) row <= RW'(1);
         else if (state == S_CAPTURE)         row <= row + RW'(1);
         if (state == S_DRAIN) begin
            if (advance) begin
               out_valid <= p1_valid;
               out_last  <= p1_last;
               out_data  <= lane_rdata[p1_bank];
               p1_valid  <= rd_en;
               p1_last   <= rd_en && rd_idx == (L2N+1)'(N-1);
               p1_bank   <= rd_k[1:0];
               if (rd_en) rd_idx <= rd_idx + (L2N+1)'(1);
            end
         end else begin
            rd_idx    <= '0;
            p1_valid  <= 1'b0;
            p1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_unloader.sv
// Directed bench for fft_frame_unloader: ramp, bit-reverse, backpressure,
// ignored controls, mid-drain reset and full-scale frames.
module tb_fft_frame_unloader;
   import fft_pkg::*;

   localparam int W = 2 * NBITS_out;

   logic         clk = 0;
   logic         rst = 1;
   logic [W-1:0] lane0u, lane0d, lane1u, lane1d;
   logic         frame_start = 0, arm = 0, bitrev = 0, out_ready = 1;
   logic [W-1:0] out_data;
   logic         out_valid, out_last, busy;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   fft_frame_unloader dut (
      .clk(clk), .rst(rst),
      .fftOut0_up(lane0u), .fftOut0_down(lane0d),
      .fftOut1_up(lane1u), .fftOut1_down(lane1d),
      .frame_start(frame_start), .arm(arm), .bitrev(bitrev),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Stimulus patterns: 0 ramp re=k, 1 full-scale corners, 2 offset ramp.
   function automatic logic [W-1:0] sample(input int pat, input int k);
      logic [NBITS_out-1:0] re, im;
      case (pat)
         0: begin re = NBITS_out'(k); im = '0; end
         1: begin
            re = k[0] ? 21'h0FFFFF : 21'h100000;
            im = k[1] ? 21'h100000 : 21'h0FFFFF;
         end
         default: begin re = NBITS_out'(1000 + k); im = NBITS_out'(3 * k); end
      endcase
      return {re, im};
   endfunction

   function automatic int brev7(input int k);
      int r;
      r = 0;
      for (int b = 0; b < 7; b++) r[6-b] = k[b];
      return r;
   endfunction

   task automatic drive_junk();
      lane0u = 42'h2AAAAAAAAAA;
      lane0d = 42'h15555555555;
      lane1u = 42'h3FFFFFFFFFF;
      lane1d = 42'h12345678ABC;
      frame_start = 0;
      arm = 0;
   endtask

   task automatic arm_dut(input bit brev, input bit fs_same);
      @(posedge clk); #1;
      arm = 1; bitrev = brev; frame_start = fs_same;
      @(posedge clk); #1;
      arm = 0; frame_start = 0; bitrev = ~brev;
      @(negedge clk);
      check("armed_busy", busy, 1);
   endtask

   task automatic send_frame(input int pat, input int fs_extra, input int arm_extra, output int c);
      c = 0;
      for (int r = 0; r < 32; r++) begin
         @(posedge clk); #1;
         if (r == 0) c = cyc + 1;
         lane0u = sample(pat, 4*r);
         lane0d = sample(pat, 4*r + 1);
         lane1u = sample(pat, 4*r + 2);
         lane1d = sample(pat, 4*r + 3);
         frame_start = (r == 0) || (r == fs_extra);
         arm = (r == arm_extra);
      end
      @(posedge clk); #1;
      drive_junk();
   endtask

   task automatic drain(input int pat, input bit brev, input bit bp, input int c, input int stop_after);
      int beat, budget, k;
      bit stalled, rdy, first_seen;
      logic [W-1:0] held_data;
      logic held_last;
      beat = 0; budget = 0; stalled = 0; first_seen = 0;
      held_data = '0; held_last = 0;
      while (beat < stop_after && budget < 4000) begin
         @(negedge clk);
         budget++;
         if (stalled) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held_data);
            check("stall_last", out_last, held_last);
         end
         if (out_valid && !first_seen) begin
            first_seen = 1;
            check("first_valid_cycle", cyc, c + 33);
         end
         rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = rdy;
         stalled = 0;
         if (out_valid && rdy) begin
            k = brev ? brev7(beat) : beat;
            check("beat_data", out_data, sample(pat, k));
            check("beat_last", out_last, beat == 127);
            if (pat == 0 && brev && beat == 1)   check("brev_beat1_re", out_data[41:21], 64);
            if (pat == 0 && brev && beat == 2)   check("brev_beat2_re", out_data[41:21], 32);
            if (pat == 0 && beat == 127)         check("beat127_re", out_data[41:21], 127);
            if (!bp && beat == 127)              check("last_cycle", cyc, c + 160);
            beat++;
         end else if (out_valid) begin
            stalled = 1;
            held_data = out_data;
            held_last = out_last;
         end
      end
      out_ready = 1;
      check("beats_drained", beat, stop_after);
   endtask

   task automatic check_idle_after(input string tag);
      @(negedge clk);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid"}, out_valid, 0);
   endtask

   initial begin
      int c, extra;
      drive_junk();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_data", out_data, 0);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_busy", busy, 0);
      rst = 0;

      // Ramp; frame_start coinciding with arm in IDLE must not start capture.
      arm_dut(0, 1);
      repeat (3) @(posedge clk);
      send_frame(0, -1, -1, c);
      drain(0, 0, 0, c, 128);
      check_idle_after("ramp_end");

      arm_dut(1, 0);
      send_frame(0, -1, -1, c);
      drain(0, 1, 0, c, 128);
      check_idle_after("brev_end");

      arm_dut(0, 0);
      send_frame(0, -1, -1, c);
      drain(0, 0, 1, c, 128);
      check_idle_after("bp_end");

      // Second arm during capture and stray frame_start at c+10 are ignored.
      arm_dut(0, 0);
      send_frame(0, 10, 5, c);
      drain(0, 0, 0, c, 128);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy || out_valid) extra++;
      end
      check("one_frame_only", extra, 0);

      // Reset right after beat 50 handshakes.
      arm_dut(0, 0);
      send_frame(0, -1, -1, c);
      drain(0, 0, 0, c, 51);
      rst = 1;
      @(negedge clk);
      check("midrst_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_data", out_data, 0);
      rst = 0;
      arm_dut(0, 0);
      send_frame(2, -1, -1, c);
      drain(2, 0, 0, c, 128);
      check_idle_after("rearm_end");

      arm_dut(0, 0);
      send_frame(1, -1, -1, c);
      drain(1, 0, 1, c, 128);
      check_idle_after("fullscale_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
